// File: rtl/nand4_seq_pkg.sv
// Shared types and helpers for the NAND4 stimulus sequencer: state encoding,
// pattern count and the binary-to-Gray mapping used by the optional Gray order.
package nand4_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } seq_state_t;

   localparam int         NUM_PATTERNS = 16;
   localparam logic [3:0] LAST_IDX     = 4'(NUM_PATTERNS - 1);

   function automatic logic [3:0] bin_to_gray(input logic [3:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/nand4_dwell_timer.sv
// Dwell timer: CNT_W-bit down-counter with synchronous load and enable;
// expired flags the terminal count of zero.
module nand4_dwell_timer
   import nand4_seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             enable,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (enable && !expired) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/nand4_stimulus_sequencer.sv
// Steps the NAND4 inputs A..D through all 16 patterns, each held DWELL_CYCLES cycles.
// Define NAND4_SEQ_GRAY_EN to apply patterns in Gray-code order instead of binary.
//
// state  | meaning
// IDLE   | outputs zero, waiting for start
// RUN    | pattern applied and stable, dwell timer counting
// PAUSED | pattern and remaining dwell frozen while pause is high
// DONE   | one-cycle completion pulse, then back to IDLE
module nand4_stimulus_sequencer
   import nand4_seq_pkg::*;
#(
   parameter int DWELL_CYCLES = 50,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       loop,
   input  logic       pause,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   output logic [3:0] pattern_idx,
   output logic       valid,
   output logic       busy,
   output logic       done
);

   seq_state_t state;
   logic [3:0] idx;
   logic [3:0] pattern;
   logic       expired;
   logic       timer_load;
   logic       timer_en;

   function automatic logic [3:0] map_pattern(input logic [3:0] i);
`ifdef NAND4_SEQ_GRAY_EN
      return bin_to_gray(i);
`else
      return i;
`endif
   endfunction

   // Reload on every expiry, including the final one; the value is unused after DONE.
   assign timer_load = ((state == IDLE) && start) || ((state == RUN) && !pause && expired);
   assign timer_en   = (state == RUN) && !pause;

   nand4_dwell_timer #(
      .CNT_W (CNT_W)
   ) u_dwell_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .enable   (timer_en),
      .load_val (CNT_W'(DWELL_CYCLES - 1)),
      .expired  (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= 4'd0;
         pattern <= 4'd0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  idx     <= 4'd0;
                  pattern <= map_pattern(4'd0);
                  valid   <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            RUN: begin
               // Pause takes priority over expiry; the expiry is seen again after resume.
               if (pause) begin
                  state <= PAUSED;
                  valid <= 1'b0;
               end else if (expired) begin
                  if (idx != LAST_IDX) begin
                     idx     <= idx + 4'd1;
                     pattern <= map_pattern(idx + 4'd1);
                  end else if (loop) begin
                     idx     <= 4'd0;
                     pattern <= map_pattern(4'd0);
                  end else begin
                     state   <= DONE;
                     idx     <= 4'd0;
                     pattern <= 4'd0;
                     valid   <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            PAUSED: begin
               if (!pause) begin
                  state <= RUN;
                  valid <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign {A, B, C, D} = pattern;
   assign pattern_idx  = idx;

endmodule

// File: tb/tb_nand4_stimulus_sequencer.sv
// Bench for nand4_stimulus_sequencer: three instances (dwell 4, 2, 1) share stimulus and
// are compared every cycle against a progress-count reference model.
module tb_nand4_stimulus_sequencer;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic loop = 1'b0;
   logic pause = 1'b0;

   logic [2:0] dut_a, dut_b, dut_c, dut_d, dut_valid, dut_busy, dut_done;
   logic [3:0] dut_idx [3];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int          mode [3];
   int unsigned prog [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      nand4_stimulus_sequencer #(
         .DWELL_CYCLES (4 >> g),
         .CNT_W        (16)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .start       (start),
         .loop        (loop),
         .pause       (pause),
         .A           (dut_a[g]),
         .B           (dut_b[g]),
         .C           (dut_c[g]),
         .D           (dut_d[g]),
         .pattern_idx (dut_idx[g]),
         .valid       (dut_valid[g]),
         .busy        (dut_busy[g]),
         .done        (dut_done[g])
      );
   end

   function automatic int unsigned dw(input int k);
      return 32'd4 >> k;
   endfunction

   function automatic logic [3:0] ref_pattern(input logic [3:0] i);
`ifdef NAND4_SEQ_GRAY_EN
      return i ^ (i >> 1);
`else
      return i;
`endif
   endfunction

   // Reference: prog counts RUN cycles consumed since start; index = prog / dwell.
   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            mode[k] <= M_IDLE;
            prog[k] <= 0;
         end else begin
            case (mode[k])
               M_IDLE: if (start) begin
                  mode[k] <= M_RUN;
                  prog[k] <= 0;
               end
               M_RUN: begin
                  if (pause) mode[k] <= M_PAUSE;
                  else if (prog[k] + 1 == 16 * dw(k)) begin
                     prog[k] <= 0;
                     if (!loop) mode[k] <= M_DONE;
                  end else prog[k] <= prog[k] + 1;
               end
               M_PAUSE: if (!pause) mode[k] <= M_RUN;
               default: mode[k] <= M_IDLE;
            endcase
         end
      end
   end

   function automatic logic [10:0] expv(input int k);
      logic [3:0] i;
      logic       active;
      active = (mode[k] == M_RUN) || (mode[k] == M_PAUSE);
      i = active ? 4'((prog[k] / dw(k)) % 16) : 4'd0;
      return {ref_pattern(i), i, mode[k] == M_RUN, active, mode[k] == M_DONE};
   endfunction

   function automatic logic [10:0] obs(input int k);
      return {dut_a[k], dut_b[k], dut_c[k], dut_d[k], dut_idx[k],
              dut_valid[k], dut_busy[k], dut_done[k]};
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (obs(k) !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state inst%0d: got %b want %b", k, obs(k), 11'd0);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_pass();
      int first_valid = -1;
      int done_at = -1;
      loop = 1'b0;
      start = 1'b1;
      for (int c = 0; c < 72; c++) begin
         @(negedge clk);
         start = 1'b0;
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs(k) !== expv(k)) begin
               n_fail++;
               $display("FAIL single_pass inst%0d cyc%0d: got %b want %b", k, cyc, obs(k), expv(k));
            end
         end
         if (dut_valid[0] && first_valid < 0) first_valid = c;
         if (dut_done[0] && done_at < 0) done_at = c;
      end
      n_tests++;
      if (done_at - first_valid != 64) begin
         n_fail++;
         $display("FAIL done_latency: got %0d cycles want 64", done_at - first_valid);
      end
   endtask

   task automatic test_loop();
      logic [3:0] prev;
      logic       prev_ok;
      prev = 4'd0;
      prev_ok = 1'b0;
      loop = 1'b1;
      pulse_start();
      for (int c = 0; c < 180; c++) begin
         if (c == 100) loop = 1'b0;
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs(k) !== expv(k)) begin
               n_fail++;
               $display("FAIL loop inst%0d cyc%0d: got %b want %b", k, cyc, obs(k), expv(k));
            end
         end
`ifdef NAND4_SEQ_GRAY_EN
         if (prev_ok && dut_valid[2]) begin
            n_tests++;
            if ($countones(prev ^ {dut_a[2], dut_b[2], dut_c[2], dut_d[2]}) != 1) begin
               n_fail++;
               $display("FAIL gray_step cyc%0d: got %b after %b want distance 1",
                        cyc, {dut_a[2], dut_b[2], dut_c[2], dut_d[2]}, prev);
            end
         end
`endif
         prev = {dut_a[2], dut_b[2], dut_c[2], dut_d[2]};
         prev_ok = dut_valid[2];
         @(negedge clk);
      end
      n_tests++;
      if (dut_busy !== 3'b000) begin
         n_fail++;
         $display("FAIL loop_stop: busy got %b want 000", dut_busy);
      end
   endtask

   task automatic test_pause();
      int paused_cnt = 0;
      int hold_cnt = 0;
      bit found = 0;
      loop = 1'b0;
      pulse_start();
      for (int c = 0; c < 60 && !found; c++) begin
         if (dut_valid[0] && dut_idx[0] == 4'd6 && prog[0] % 4 == 2) found = 1;
         else @(negedge clk);
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL pause_reach: pattern 6 with 2 dwell left not seen");
      end
      pause = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (!dut_valid[0] && dut_idx[0] == 4'd6) paused_cnt++;
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs(k) !== expv(k)) begin
               n_fail++;
               $display("FAIL pause inst%0d cyc%0d: got %b want %b", k, cyc, obs(k), expv(k));
            end
         end
      end
      pause = 1'b0;
      n_tests++;
      if (paused_cnt != 5) begin
         n_fail++;
         $display("FAIL pause_frozen: got %0d frozen cycles want 5", paused_cnt);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (dut_valid[0] && dut_idx[0] == 4'd6) hold_cnt++;
         if (dut_idx[0] == 4'd7) break;
      end
      n_tests++;
      if (hold_cnt != 2 || dut_idx[0] !== 4'd7) begin
         n_fail++;
         $display("FAIL pause_resume: got %0d hold cycles then idx %0d want 2 then 7",
                  hold_cnt, dut_idx[0]);
      end
      for (int c = 0; c < 80; c++) begin
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs(k) !== expv(k)) begin
               n_fail++;
               $display("FAIL pause_drain inst%0d cyc%0d: got %b want %b", k, cyc, obs(k), expv(k));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      loop = 1'b1;
      pulse_start();
      for (int c = 0; c < 100 && !found; c++) begin
         if (dut_valid[0] && dut_idx[0] == 4'd10) found = 1;
         else @(negedge clk);
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL reset_mid_reach: pattern 10 not seen");
      end
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (obs(k) !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid inst%0d: got %b want %b", k, obs(k), 11'd0);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      loop = 1'b0;
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (obs(k) !== expv(k) || !dut_valid[k] || dut_idx[k] !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_restart inst%0d: got %b want %b", k, obs(k), expv(k));
         end
      end
      repeat (70) @(negedge clk);
   endtask

   task automatic test_start_while_busy();
      loop = 1'b0;
      pause = 1'b0;
      pulse_start();
      for (int c = 0; c < 120; c++) begin
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs(k) !== expv(k)) begin
               n_fail++;
               $display("FAIL start_busy inst%0d cyc%0d: got %b want %b", k, cyc, obs(k), expv(k));
            end
         end
         start = (c < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 900; c++) begin
         start = ($urandom_range(0, 7) == 0);
         pause = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 19) == 0) loop = 1'($urandom_range(0, 1));
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs(k) !== expv(k)) begin
               n_fail++;
               $display("FAIL random inst%0d cyc%0d: got %b want %b", k, cyc, obs(k), expv(k));
            end
         end
      end
      start = 1'b0;
      pause = 1'b0;
      loop = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs(k) !== expv(k)) begin
               n_fail++;
               $display("FAIL random_drain inst%0d cyc%0d: got %b want %b", k, cyc, obs(k), expv(k));
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_pass();
      test_loop();
      test_pause();
      test_reset_mid();
      test_start_while_busy();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
